// File: rtl/bp_cacc_wormhole_packet_assembler.sv
// Wormhole receive side: collects a header flit plus len body flits into one packet
// buffer and hands it to the consumer over valid/yumi.
module bp_cacc_wormhole_packet_assembler #(
   parameter int flit_width_p        = 64,
   parameter int cord_width_p        = 7,
   parameter int len_width_p         = 4,
   parameter int max_payload_width_p = 512,
   localparam int packet_width_lp    = cord_width_p + len_width_p + max_payload_width_p
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic [flit_width_p-1:0]    flit_i,
   input  logic                       flit_v_i,
   output logic                       flit_ready_and_o,
   output logic [packet_width_lp-1:0] packet_o,
   output logic                       packet_v_o,
   input  logic                       packet_yumi_i,
   output logic                       overflow_o
);

   localparam int max_flits_lp = (packet_width_lp + flit_width_p - 1) / flit_width_p;
   localparam int max_len_lp   = max_flits_lp - 1;
   localparam int slot_w_lp    = $clog2(max_flits_lp + 1);
   localparam logic [slot_w_lp-1:0] max_len_s_lp = slot_w_lp'(max_len_lp);

   typedef enum logic [1:0] {IDLE, BODY, FULL} state_e;

   state_e                 state_q, state_n;
   logic [len_width_p-1:0] rem_q, rem_n, hdr_len;
   logic [slot_w_lp-1:0]   slot_q, slot_n;
   logic                   rdy_q, v_q, ovf_q;
   logic                   accept, hdr_acc, body_wr;

   assign hdr_len = flit_i[cord_width_p +: len_width_p];
   assign accept  = flit_v_i & rdy_q;
   assign hdr_acc = accept & (state_q == IDLE);
   // Body flits past the last slot are still consumed, just not stored.
   assign body_wr = accept & (state_q == BODY) & (slot_q <= max_len_s_lp);

   always_comb begin
      state_n = state_q;
      rem_n   = rem_q;
      slot_n  = slot_q;
      case (state_q)
         IDLE: if (accept) begin
            rem_n   = hdr_len;
            slot_n  = slot_w_lp'(1);
            state_n = (hdr_len == '0) ? FULL : BODY;
         end
         BODY: if (accept) begin
            rem_n = rem_q - 1'b1;
            if (body_wr) slot_n = slot_q + 1'b1;
            if (rem_q == len_width_p'(1)) state_n = FULL;
         end
         FULL: if (packet_yumi_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Handshake outputs are registered decodes of the next state.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         slot_q  <= '0;
         rdy_q   <= 1'b0;
         v_q     <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         rem_q   <= rem_n;
         slot_q  <= slot_n;
         rdy_q   <= (state_n != FULL);
         v_q     <= (state_n == FULL);
         if (hdr_acc && (32'(hdr_len) > max_len_lp)) ovf_q <= 1'b1;
      end
   end

   // One register per slot; the last slot only keeps the bits that fit in the packet.
   for (genvar k = 0; k < max_flits_lp; k++) begin : g_slot
      localparam int lo_lp = k * flit_width_p;
      localparam int w_lp  = (packet_width_lp - lo_lp < flit_width_p) ?
                             (packet_width_lp - lo_lp) : flit_width_p;
      logic [w_lp-1:0] q;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i)
            q <= '0;
         else if (hdr_acc)
            q <= (k == 0) ? flit_i[w_lp-1:0] : '0;
         else if (body_wr && (slot_q == slot_w_lp'(k)))
            q <= flit_i[w_lp-1:0];
      end

      assign packet_o[lo_lp +: w_lp] = q;
   end

   assign flit_ready_and_o = rdy_q;
   assign packet_v_o       = v_q;
   assign overflow_o       = ovf_q;

   a_yumi_in_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    packet_yumi_i |-> packet_v_o);

endmodule

// File: tb/tb_bp_cacc_wormhole_packet_assembler.sv
// Directed bench for the wormhole packet assembler at default parameters
// (523-bit packet, 9 flit slots, max len 8).
module tb_bp_cacc_wormhole_packet_assembler;

   localparam int PW = 523;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic [63:0]   flit_i;
   logic          flit_v_i;
   logic          flit_ready_and_o;
   logic [PW-1:0] packet_o;
   logic          packet_v_o;
   logic          packet_yumi_i;
   logic          overflow_o;

   int checks   = 0;
   int failures = 0;

   logic [63:0] ef [9];

   bp_cacc_wormhole_packet_assembler dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .flit_i           (flit_i),
      .flit_v_i         (flit_v_i),
      .flit_ready_and_o (flit_ready_and_o),
      .packet_o         (packet_o),
      .packet_v_o       (packet_v_o),
      .packet_yumi_i    (packet_yumi_i),
      .overflow_o       (overflow_o)
   );

   initial forever #5 clk_i = ~clk_i;

   function automatic logic [63:0] hdr(input int len, input int cord, input logic [52:0] data);
      return {data, 4'(len), 7'(cord)};
   endfunction

   function automatic logic [PW-1:0] pack_exp();
      logic [575:0] w;
      w = '0;
      for (int k = 0; k < 9; k++) w[k*64 +: 64] = ef[k];
      return w[PW-1:0];
   endfunction

   task automatic clr_ef();
      for (int k = 0; k < 9; k++) ef[k] = '0;
   endtask

   // Present a flit and wait (bounded) until it is accepted; returns 1 time unit after the accept edge.
   task automatic send(input logic [63:0] f);
      int n;
      n = 0;
      @(negedge clk_i);
      flit_i   = f;
      flit_v_i = 1'b1;
      while (!flit_ready_and_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL send_timeout: flit %h not accepted, ready=%b required 1", f, flit_ready_and_o);
      end else begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_yumi();
      @(negedge clk_i);
      flit_v_i      = 1'b0;
      packet_yumi_i = 1'b1;
      @(posedge clk_i);
      #1;
      packet_yumi_i = 1'b0;
      checks++;
      if (packet_v_o !== 1'b0) begin
         failures++;
         $display("FAIL yumi_v: packet_v_o=%b required 0", packet_v_o);
      end
      checks++;
      if (flit_ready_and_o !== 1'b1) begin
         failures++;
         $display("FAIL yumi_ready: ready=%b required 1", flit_ready_and_o);
      end
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0; flit_v_i = 1'b0; flit_i = '0; packet_yumi_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (flit_ready_and_o !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b required 0", flit_ready_and_o); end
      checks++; if (packet_v_o !== 1'b0)       begin failures++; $display("FAIL rst_v: got %b required 0", packet_v_o); end
      checks++; if (overflow_o !== 1'b0)       begin failures++; $display("FAIL rst_ovf: got %b required 0", overflow_o); end
      checks++; if (packet_o !== '0)           begin failures++; $display("FAIL rst_packet: got %h required 0", packet_o); end
      @(negedge clk_i);
      reset_n_i = 1'b1;
      #1;
      checks++; if (flit_ready_and_o !== 1'b0) begin failures++; $display("FAIL rel_ready: got %b required 0", flit_ready_and_o); end
      @(posedge clk_i);
      #1;
      checks++; if (flit_ready_and_o !== 1'b1) begin failures++; $display("FAIL rel_ready_rise: got %b required 1", flit_ready_and_o); end
   endtask

   task automatic test_single();
      clr_ef();
      ef[0] = hdr(0, 5, 53'hA5);
      send(ef[0]);
      checks++; if (packet_v_o !== 1'b1)       begin failures++; $display("FAIL single_v: got %b required 1", packet_v_o); end
      checks++; if (flit_ready_and_o !== 1'b0) begin failures++; $display("FAIL single_ready: got %b required 0", flit_ready_and_o); end
      checks++; if (packet_o !== pack_exp())   begin failures++; $display("FAIL single_packet: got %h required %h", packet_o, pack_exp()); end
      do_yumi();
   endtask

   task automatic test_max_packet();
      clr_ef();
      ef[0] = hdr(8, 3, 53'h1234);
      for (int k = 1; k < 9; k++) ef[k] = 64'h0101_0101_0101_0101 * 64'(k);
      for (int k = 0; k < 9; k++) begin
         send(ef[k]);
         if (k == 7) begin
            checks++; if (packet_v_o !== 1'b0) begin failures++; $display("FAIL max_early_v: got %b required 0", packet_v_o); end
         end
      end
      checks++; if (packet_v_o !== 1'b1)     begin failures++; $display("FAIL max_v: got %b required 1", packet_v_o); end
      checks++; if (packet_o !== pack_exp()) begin failures++; $display("FAIL max_packet: got %h required %h", packet_o, pack_exp()); end
      do_yumi();
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] p1;
      clr_ef();
      ef[0] = hdr(1, 2, 53'h77);
      ef[1] = 64'hDEAD_BEEF_0123_4567;
      p1 = pack_exp();
      send(ef[0]);
      send(ef[1]);
      checks++; if (packet_v_o !== 1'b1) begin failures++; $display("FAIL bp_v: got %b required 1", packet_v_o); end
      clr_ef();
      ef[0] = hdr(0, 9, 53'h3C);
      @(negedge clk_i);
      flit_i   = ef[0];
      flit_v_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         checks++; if (flit_ready_and_o !== 1'b0) begin failures++; $display("FAIL bp_ready cyc %0d: got %b required 0", c, flit_ready_and_o); end
         checks++; if (packet_o !== p1)           begin failures++; $display("FAIL bp_stable cyc %0d: got %h required %h", c, packet_o, p1); end
      end
      packet_yumi_i = 1'b1;
      @(posedge clk_i);
      #1;
      packet_yumi_i = 1'b0;
      checks++; if (flit_ready_and_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after: got %b required 1", flit_ready_and_o); end
      checks++; if (packet_v_o !== 1'b0)       begin failures++; $display("FAIL bp_v_after: got %b required 0", packet_v_o); end
      @(posedge clk_i);
      #1;
      checks++; if (packet_v_o !== 1'b1)     begin failures++; $display("FAIL bp_next_v: got %b required 1", packet_v_o); end
      checks++; if (packet_o !== pack_exp()) begin failures++; $display("FAIL bp_next_packet: got %h required %h", packet_o, pack_exp()); end
      do_yumi();
   endtask

   task automatic test_gaps();
      clr_ef();
      ef[0] = hdr(3, 1, 53'h55);
      ef[1] = 64'h1111_2222_3333_4444;
      ef[2] = 64'h5555_6666_7777_8888;
      ef[3] = 64'h9999_AAAA_BBBB_CCCC;
      for (int k = 0; k < 4; k++) begin
         send(ef[k]);
         if (k < 3) begin
            checks++; if (packet_v_o !== 1'b0) begin failures++; $display("FAIL gap_v flit %0d: got %b required 0", k, packet_v_o); end
            @(negedge clk_i);
            flit_v_i = 1'b0;
            flit_i   = 64'hFFFF_FFFF_FFFF_FFFF;
         end
      end
      checks++; if (packet_v_o !== 1'b1)     begin failures++; $display("FAIL gap_final_v: got %b required 1", packet_v_o); end
      checks++; if (packet_o !== pack_exp()) begin failures++; $display("FAIL gap_packet: got %h required %h", packet_o, pack_exp()); end
      do_yumi();
   endtask

   task automatic test_oversize();
      clr_ef();
      ef[0] = hdr(15, 4, 53'hABC);
      for (int k = 1; k < 9; k++) ef[k] = 64'h1000 + 64'(k);
      checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_pre: got %b required 0", overflow_o); end
      send(ef[0]);
      checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b required 1", overflow_o); end
      for (int k = 1; k < 16; k++) begin
         send((k < 9) ? ef[k] : {16{4'(k)}});
         if (k == 14) begin
            checks++; if (packet_v_o !== 1'b0) begin failures++; $display("FAIL ovf_early_v: got %b required 0", packet_v_o); end
         end
      end
      checks++; if (packet_v_o !== 1'b1)     begin failures++; $display("FAIL ovf_v: got %b required 1", packet_v_o); end
      checks++; if (packet_o !== pack_exp()) begin failures++; $display("FAIL ovf_packet: got %h required %h", packet_o, pack_exp()); end
      do_yumi();
      clr_ef();
      ef[0] = hdr(1, 6, 53'h42);
      ef[1] = 64'hCAFE;
      send(ef[0]);
      send(ef[1]);
      checks++; if (packet_o !== pack_exp()) begin failures++; $display("FAIL ovf_good_packet: got %h required %h", packet_o, pack_exp()); end
      checks++; if (overflow_o !== 1'b1)     begin failures++; $display("FAIL ovf_sticky: got %b required 1", overflow_o); end
      do_yumi();
   endtask

   task automatic test_async_reset();
      send(hdr(5, 1, 53'h99));
      send(64'h0123);
      send(64'h4567);
      @(negedge clk_i);
      flit_v_i = 1'b0;
      #2;
      reset_n_i = 1'b0;
      #1;
      checks++; if (flit_ready_and_o !== 1'b0) begin failures++; $display("FAIL ar_ready: got %b required 0", flit_ready_and_o); end
      checks++; if (packet_v_o !== 1'b0)       begin failures++; $display("FAIL ar_v: got %b required 0", packet_v_o); end
      checks++; if (packet_o !== '0)           begin failures++; $display("FAIL ar_packet: got %h required 0", packet_o); end
      checks++; if (overflow_o !== 1'b0)       begin failures++; $display("FAIL ar_ovf: got %b required 0", overflow_o); end
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      checks++; if (flit_ready_and_o !== 1'b1) begin failures++; $display("FAIL ar_ready_rise: got %b required 1", flit_ready_and_o); end
      clr_ef();
      ef[0] = hdr(1, 3, 53'h11);
      ef[1] = 64'h0F0F;
      send(ef[0]);
      send(ef[1]);
      checks++; if (packet_v_o !== 1'b1)     begin failures++; $display("FAIL ar_new_v: got %b required 1", packet_v_o); end
      checks++; if (packet_o !== pack_exp()) begin failures++; $display("FAIL ar_new_packet: got %h required %h", packet_o, pack_exp()); end
      do_yumi();
   endtask

   initial begin
      test_reset();
      test_single();
      test_max_packet();
      test_backpressure();
      test_gaps();
      test_oversize();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
